// File: rtl/seri_paralel_toplayici.sv
// Serial-to-parallel collector: assembles 8 N-bit words into a packet held on sayi1..sayi8.
// Double-buffered shadow/output banks with one-cycle giris_etkin strobe per completed packet.
module seri_paralel_toplayici #(
    parameter int unsigned N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  veri_giris,
    input  logic          veri_gecerli,
    output logic          veri_hazir,
    input  logic          durdur,
    input  logic          temizle,
    output logic [N-1:0]  sayi1,
    output logic [N-1:0]  sayi2,
    output logic [N-1:0]  sayi3,
    output logic [N-1:0]  sayi4,
    output logic [N-1:0]  sayi5,
    output logic [N-1:0]  sayi6,
    output logic [N-1:0]  sayi7,
    output logic [N-1:0]  sayi8,
    output logic          giris_etkin,
    output logic [15:0]   paket_sayisi,
    output logic          kayip
);

    logic [N-1:0] r_golge [8];
    logic [N-1:0] r_cikis [8];
    logic [2:0]   r_idx;
    logic         r_hazir;
    logic         r_etkin;
    logic [15:0]  r_paket_sayisi;
    logic         r_kayip;

    logic         w_kabul;
    logic         w_son;

    // temizle wins over a simultaneous accept, so the word is simply dropped.
    assign w_kabul = veri_gecerli & r_hazir & ~temizle;
    assign w_son   = w_kabul & (r_idx == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hazir <= 1'b0;
            r_kayip <= 1'b0;
        end else begin
            r_hazir <= ~durdur;
            if (veri_gecerli && !r_hazir) begin
                r_kayip <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                r_golge[i] <= '0;
            end
        end else if (temizle) begin
            r_idx <= 3'd0;
        end else if (w_kabul) begin
            r_golge[r_idx] <= veri_giris;
            r_idx          <= r_idx + 3'd1;
        end
    end

    // Output bank loads from the shadow bank plus the word arriving in slot 8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_etkin        <= 1'b0;
            r_paket_sayisi <= 16'd0;
            for (int i = 0; i < 8; i++) begin
                r_cikis[i] <= '0;
            end
        end else begin
            r_etkin <= w_son;
            if (w_son) begin
                for (int i = 0; i < 7; i++) begin
                    r_cikis[i] <= r_golge[i];
                end
                r_cikis[7]     <= veri_giris;
                r_paket_sayisi <= r_paket_sayisi + 16'd1;
            end
        end
    end

    assign veri_hazir   = r_hazir;
    assign giris_etkin  = r_etkin;
    assign paket_sayisi = r_paket_sayisi;
    assign kayip        = r_kayip;
    assign sayi1        = r_cikis[0];
    assign sayi2        = r_cikis[1];
    assign sayi3        = r_cikis[2];
    assign sayi4        = r_cikis[3];
    assign sayi5        = r_cikis[4];
    assign sayi6        = r_cikis[5];
    assign sayi7        = r_cikis[6];
    assign sayi8        = r_cikis[7];

endmodule

// File: tb/tb_seri_paralel_toplayici.sv
// Scoreboard bench for seri_paralel_toplayici: a queue-based packet model feeds expected
// packets to a negedge monitor that checks strobes, held outputs, veri_hazir and kayip.
module tb_seri_paralel_toplayici;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] veri_giris = '0;
    logic         veri_gecerli = 1'b0;
    logic         durdur = 1'b0;
    logic         temizle = 1'b0;
    logic         veri_hazir;
    logic [N-1:0] sayi1, sayi2, sayi3, sayi4, sayi5, sayi6, sayi7, sayi8;
    logic         giris_etkin;
    logic [15:0]  paket_sayisi;
    logic         kayip;

    seri_paralel_toplayici #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .veri_giris   (veri_giris),
        .veri_gecerli (veri_gecerli),
        .veri_hazir   (veri_hazir),
        .durdur       (durdur),
        .temizle      (temizle),
        .sayi1        (sayi1),
        .sayi2        (sayi2),
        .sayi3        (sayi3),
        .sayi4        (sayi4),
        .sayi5        (sayi5),
        .sayi6        (sayi6),
        .sayi7        (sayi7),
        .sayi8        (sayi8),
        .giris_etkin  (giris_etkin),
        .paket_sayisi (paket_sayisi),
        .kayip        (kayip)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][N-1:0] w;
        logic [15:0]       cnt;
    } pkt_t;

    pkt_t              sb[$];
    logic [N-1:0]      m_part[$];
    logic              m_hazir = 1'b0;
    logic              m_kayip = 1'b0;
    logic [15:0]       m_sayac = 16'd0;
    logic [7:0][N-1:0] m_cikis = '0;
    int                n_vec = 0;
    int                n_err = 0;

    logic [N-1:0] w_out [8];
    assign w_out[0] = sayi1;
    assign w_out[1] = sayi2;
    assign w_out[2] = sayi3;
    assign w_out[3] = sayi4;
    assign w_out[4] = sayi5;
    assign w_out[5] = sayi6;
    assign w_out[6] = sayi7;
    assign w_out[7] = sayi8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected packet per strobe, otherwise outputs must hold.
    always @(negedge clk) begin
        pkt_t p;
        chk("veri_hazir", veri_hazir, m_hazir);
        chk("kayip", kayip, m_kayip);
        if (giris_etkin === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious strobe", giris_etkin, 0);
            end else begin
                p = sb.pop_front();
                for (int i = 0; i < 8; i++) chk($sformatf("sayi%0d", i + 1), w_out[i], p.w[i]);
                chk("paket_sayisi", paket_sayisi, p.cnt);
                m_cikis = p.w;
            end
        end else begin
            if (sb.size() != 0) begin
                chk("missed strobe", giris_etkin, 1);
                p = sb.pop_front();
                m_cikis = p.w;
            end
            for (int i = 0; i < 8; i++) chk($sformatf("held sayi%0d", i + 1), w_out[i], m_cikis[i]);
        end
    end

    // One clock of stimulus; the model is advanced from the inputs seen at that edge.
    task automatic step(input logic v, input logic [N-1:0] d, input logic st, input logic tz,
                        output bit acc);
        pkt_t p;
        veri_gecerli = v;
        veri_giris   = d;
        durdur       = st;
        temizle      = tz;
        @(posedge clk);
        #1;
        acc = 1'b0;
        if (v && !m_hazir) m_kayip = 1'b1;
        if (tz) begin
            m_part.delete();
        end else if (v && m_hazir) begin
            acc = 1'b1;
            m_part.push_back(d);
            if (m_part.size() == 8) begin
                m_sayac = m_sayac + 16'd1;
                for (int i = 0; i < 8; i++) p.w[i] = m_part[i];
                p.cnt = m_sayac;
                sb.push_back(p);
                m_part.delete();
            end
        end
        m_hazir = !st;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic send_word(input logic [N-1:0] d);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            step(1'b1, d, 1'b0, 1'b0, acc);
            tries++;
        end
        if (!acc) chk("word accept timeout", 0, 1);
    endtask

    task automatic do_reset();
        #2;
        rst_n        = 1'b0;
        veri_gecerli = 1'b0;
        durdur       = 1'b0;
        temizle      = 1'b0;
        m_part.delete();
        sb.delete();
        m_hazir = 1'b0;
        m_kayip = 1'b0;
        m_sayac = 16'd0;
        m_cikis = '0;
        #1;
        chk("rst veri_hazir", veri_hazir, 0);
        chk("rst giris_etkin", giris_etkin, 0);
        chk("rst paket_sayisi", paket_sayisi, 0);
        chk("rst kayip", kayip, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst sayi%0d", i + 1), w_out[i], 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_hazir = 1'b1;
    endtask

    initial begin
        bit           acc;
        logic [N-1:0] d;
        logic         v, st, tz;

        do_reset();

        // Single packet 1..8
        for (int i = 1; i <= 8; i++) send_word(N'(i));
        idle(2);

        // Two back-to-back packets 10..25
        for (int i = 10; i <= 25; i++) send_word(N'(i));
        idle(2);

        // Partial packet discarded by temizle
        for (int i = 100; i < 105; i++) send_word(N'(i));
        step(1'b0, '0, 1'b0, 1'b1, acc);
        for (int i = 40; i <= 47; i++) send_word(N'(i));
        idle(2);

        // Stall mid-packet while still offering data
        for (int i = 50; i < 53; i++) send_word(N'(i));
        d = N'(53);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, d, 1'b1, 1'b0, acc);
            if (acc) d = d + 1'b1;
        end
        for (int i = 0; i < 20 && !(acc && m_part.size() == 0); i++) begin
            step(1'b1, d, 1'b0, 1'b0, acc);
            if (acc) d = d + 1'b1;
        end
        idle(1);
        chk("kayip after stall", kayip, 1);

        // Asynchronous reset after 6 words, then a fresh packet
        for (int i = 60; i < 66; i++) send_word(N'(i));
        do_reset();
        for (int i = 70; i < 78; i++) send_word(N'(i));
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 9) == 0);
            tz = ($urandom_range(0, 31) == 0);
            step(v, N'($urandom), st, tz, acc);
        end
        idle(3);

        // Packet counter wrap
        force dut.r_paket_sayisi = 16'hFFFF;
        #1;
        release dut.r_paket_sayisi;
        m_sayac = 16'hFFFF;
        step(1'b0, '0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 8; i++) send_word(N'($urandom));
        idle(3);
        chk("paket_sayisi wrapped", paket_sayisi, 16'h0000);
        chk("scoreboard drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
